// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divider.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 32;
    localparam int unsigned DIVISOR_W  = 16;

    // Quotient reported for divide-by-zero and overflow
    localparam logic [DIVISOR_W-1:0] ERR_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

endpackage

// File: rtl/restoring_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module restoring_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   r_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] t;

    // The MSB of the partial remainder is shifted out; it is always 0 for a
    // non-overflowing division, and error results are forced by the caller.
    logic unused_r_msb;
    assign unused_r_msb = r_in[DIVISOR_W];

    // Trial subtraction; keep the shifted value if the divisor does not fit
    always_comb begin
        t = {r_in[DIVISOR_W-1:0], bit_in};
        if (t >= {1'b0, divisor}) begin
            r_out = t - {1'b0, divisor};
            q_bit = 1'b1;
        end else begin
            r_out = t;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/iterative_divider.sv
// Sequential radix-2 restoring divider, 32/16 -> 16-bit quotient and remainder,
// one quotient bit per clock, valid/ready on both sides.
// Optional macro DIVIDER_EARLY_EXIT_EN: error cases skip CALC and go straight to DONE.
module iterative_divider
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    div_state_e           state_q;
    logic [DIVISOR_W:0]   r_q;
    logic [DIVISOR_W-1:0] shift_q;    // dividend bits out at the top, quotient bits in at the bottom
    logic [DIVISOR_W-1:0] divisor_q;
    logic [3:0]           cnt_q;
    logic                 dz_q;
    logic                 ov_q;

    logic [DIVISOR_W:0]   r_next;
    logic                 q_bit;
    logic                 acc_dz;
    logic                 acc_ov;

    restoring_step u_step (
        .r_in    (r_q),
        .bit_in  (shift_q[DIVISOR_W-1]),
        .divisor (divisor_q),
        .r_out   (r_next),
        .q_bit   (q_bit)
    );

    // Error classification of the operands being offered
    always_comb begin
        acc_dz = (divisor == '0);
        acc_ov = !acc_dz && (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r_q       <= {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
                        shift_q   <= dividend[DIVISOR_W-1:0];
                        divisor_q <= divisor;
                        cnt_q     <= 4'd15;
                        dz_q      <= acc_dz;
                        ov_q      <= acc_ov;
                        in_ready  <= 1'b0;
`ifdef DIVIDER_EARLY_EXIT_EN
                        if (acc_dz || acc_ov) begin
                            state_q     <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= ERR_QUOTIENT;
                            remainder   <= '0;
                            div_by_zero <= acc_dz;
                            overflow    <= acc_ov;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_q     <= r_next;
                    shift_q <= {shift_q[DIVISOR_W-2:0], q_bit};
                    cnt_q   <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q     <= DONE;
                        out_valid   <= 1'b1;
                        div_by_zero <= dz_q;
                        overflow    <= ov_q;
                        if (dz_q || ov_q) begin
                            quotient  <= ERR_QUOTIENT;
                            remainder <= '0;
                        end else begin
                            quotient  <= {shift_q[DIVISOR_W-2:0], q_bit};
                            remainder <= r_next[DIVISOR_W-1:0];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    iterative_divider u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division plus the error rules
    task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov);
        dz = (dv == 0);
        ov = !dz && ((dd >> 16) >= {16'h0, dv});
        if (dz || ov) begin
            q = 16'hFFFF;
            r = 16'h0000;
        end else begin
            q = 16'(dd / {16'h0, dv});
            r = 16'(dd % {16'h0, dv});
        end
    endtask

    // Offer operands at a falling edge; returns at the falling edge after the accept edge
    task automatic start_op(input logic [31:0] dd, input logic [15:0] dv);
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
    endtask

    // Count clock edges after the accept edge until out_valid; junk in_valid is
    // driven meanwhile and must be ignored
    task automatic wait_result(input bit rnd_ready, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) check("result_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv);
        logic [15:0] eq, er;
        logic        edz, eov;
        int          lat, exp_lat;
        model(dd, dv, eq, er, edz, eov);
        exp_lat = 16;
`ifdef DIVIDER_EARLY_EXIT_EN
        // DONE is entered on the accept edge itself
        if (edz || eov) exp_lat = 0;
`endif
        start_op(dd, dv);
        wait_result(1'b1, lat);
        check("latency", 64'(lat), 64'(exp_lat));
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edz);
        check("overflow", overflow, eov);
        check("in_ready_in_done", in_ready, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_handshake", out_valid, 1'b0);
        check("in_ready_after_handshake", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] dd;
        logic [15:0] dv;
        logic [15:0] hi;
        int          lat;
        bit          seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_quotient", quotient, 16'h0);
        check("rst_remainder", remainder, 16'h0);
        check("rst_flags", {div_by_zero, overflow}, 2'b00);
        rst_n = 1'b1;
        out_ready = 1'b1;   // no effect while out_valid is low
        @(negedge clk);
        check("idle_out_valid", out_valid, 1'b0);
        out_ready = 1'b0;

        // Directed cases
        run_op(32'd100000, 16'd7);
        run_op(32'hFFFE0001, 16'hFFFF);
        run_op(32'h12345678, 16'h0000);
        run_op(32'h00050000, 16'd5);

        // Back-pressure: result must hold while out_ready is low
        start_op(32'd20, 16'd3);
        wait_result(1'b0, lat);
        check("hold_latency", 64'(lat), 64'd16);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_quotient", quotient, 16'd6);
            check("hold_remainder", remainder, 16'd2);
            check("hold_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("hold_in_ready_handshake", in_ready, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_in_ready_after", in_ready, 1'b1);
        check("hold_valid_after", out_valid, 1'b0);

        // Reset in the middle of CALC
        start_op(32'd1000, 16'd10);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_quotient", quotient, 16'h0);
        check("abort_remainder", remainder, 16'h0);
        check("abort_flags", {div_by_zero, overflow}, 2'b00);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 1'b0);
        run_op(32'd9, 16'd4);

        // Random operands, mostly in range with some error cases
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    dv = 16'h0;
                    dd = $urandom;
                end
                1: begin
                    dv = 16'($urandom_range(1, 65535));
                    hi = 16'($urandom_range(int'(dv), 65535));
                    dd = {hi, 16'($urandom)};
                end
                default: begin
                    dv = 16'($urandom_range(1, 65535));
                    hi = 16'($urandom_range(0, int'(dv) - 1));
                    dd = {hi, 16'($urandom)};
                end
            endcase
            run_op(dd, dv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
